// File: rtl/vga_pattern_gen_if.sv
// Pixel-stage bus: timing inputs from the sync generator, mode control, and the VGA pin outputs.
// The master side drives timing/mode; the slave (the pattern generator) drives the pins.
interface vga_pattern_gen_if #(
  parameter int COLOR_BITS = 4
);
  logic [9:0]            x_count;
  logic [9:0]            y_count;
  logic                  hsync_in;
  logic                  vsync_in;
  logic                  active_pixel;
  logic [1:0]            mode_sel;
  logic                  mode_req;
  logic [COLOR_BITS-1:0] vga_r;
  logic [COLOR_BITS-1:0] vga_g;
  logic [COLOR_BITS-1:0] vga_b;
  logic                  hsync_out;
  logic                  vsync_out;
  logic [7:0]            frame_count;

  modport master (
    output x_count, y_count, hsync_in, vsync_in, active_pixel, mode_sel, mode_req,
    input  vga_r, vga_g, vga_b, hsync_out, vsync_out, frame_count
  );

  modport slave (
    input  x_count, y_count, hsync_in, vsync_in, active_pixel, mode_sel, mode_req,
    output vga_r, vga_g, vga_b, hsync_out, vsync_out, frame_count
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel stage: bars, checker, bouncing box and gradient, registered through a
// 2-stage pipeline so colour and the re-timed syncs leave together.
module vga_pattern_gen #(
  parameter int COLOR_BITS = 4,
  parameter int BOX_SIZE   = 64,
  parameter int STEP       = 2
) (
  input  logic              clk_25,
  input  logic              rst,
  vga_pattern_gen_if.slave  bus
);

  localparam logic [COLOR_BITS-1:0] FULL  = '1;
  localparam logic [COLOR_BITS-1:0] ZERO  = '0;
  localparam logic [COLOR_BITS-1:0] ONE   = COLOR_BITS'(1);
  localparam logic [9:0]            FULL_10 = 10'((1 << COLOR_BITS) - 1);
  localparam logic [10:0]           BOX_W = 11'(BOX_SIZE);
  localparam logic [10:0]           STEP_W = 11'(STEP);
  localparam logic [10:0]           H_LIM = 11'd640;
  localparam logic [10:0]           V_LIM = 11'd480;

  logic [1:0]            mode_active, mode_pending;
  logic [7:0]            frame_count;
  logic [9:0]            box_x, box_y;
  logic                  dir_x, dir_y;
  logic                  frame_tick;
  logic [10:0]           next_x, next_y;

  logic [9:0]            s1_x, s1_y;
  logic                  s1_hsync, s1_vsync, s1_active;
  logic [1:0]            s1_mode;

  logic [COLOR_BITS-1:0] r_next, g_next, b_next;
  logic [COLOR_BITS-1:0] r_q, g_q, b_q;
  logic                  hsync_q, vsync_q;
  logic [9:0]            bar, grad;
  logic                  in_box;

  // Returns {dir, pos}; dir 0 moves towards larger coordinates, 1 towards the origin.
  function automatic logic [10:0] next_axis(input logic [9:0] pos, input logic dir,
                                            input logic [10:0] limit);
    logic [10:0] p;
    p = {1'b0, pos};
    if (!dir) begin
      if (p + BOX_W + STEP_W > limit) return {1'b1, 10'(p - STEP_W)};
      else                            return {1'b0, 10'(p + STEP_W)};
    end else begin
      if (p < STEP_W) return {1'b0, 10'(p + STEP_W)};
      else            return {1'b1, 10'(p - STEP_W)};
    end
  endfunction

  assign frame_tick = (bus.x_count == 10'd799) && (bus.y_count == 10'd524);
  assign next_x     = next_axis(box_x, dir_x, H_LIM);
  assign next_y     = next_axis(box_y, dir_y, V_LIM);

  // A request in the tick cycle lands in pending after active has already taken the old value.
  always_ff @(posedge clk_25 or negedge rst) begin
    if (!rst) begin
      mode_active  <= 2'd0;
      mode_pending <= 2'd0;
      frame_count  <= 8'd0;
      box_x        <= 10'd0;
      box_y        <= 10'd0;
      dir_x        <= 1'b0;
      dir_y        <= 1'b0;
    end else begin
      if (bus.mode_req) mode_pending <= bus.mode_sel;
      if (frame_tick) begin
        mode_active <= mode_pending;
        frame_count <= frame_count + 8'd1;
        box_x       <= next_x[9:0];
        dir_x       <= next_x[10];
        box_y       <= next_y[9:0];
        dir_y       <= next_y[10];
      end
    end
  end

  always_ff @(posedge clk_25 or negedge rst) begin
    if (!rst) begin
      s1_x      <= 10'd0;
      s1_y      <= 10'd0;
      s1_hsync  <= 1'b1;
      s1_vsync  <= 1'b1;
      s1_active <= 1'b0;
      s1_mode   <= 2'd0;
    end else begin
      s1_x      <= bus.x_count;
      s1_y      <= bus.y_count;
      s1_hsync  <= bus.hsync_in;
      s1_vsync  <= bus.vsync_in;
      s1_active <= bus.active_pixel;
      s1_mode   <= mode_active;
    end
  end

  always_comb begin
    r_next = ZERO;
    g_next = ZERO;
    b_next = ZERO;
    bar    = s1_x / 10'd80;
    grad   = s1_x / 10'd40;
    in_box = ({1'b0, s1_x} >= {1'b0, box_x}) && ({1'b0, s1_x} < {1'b0, box_x} + BOX_W) &&
             ({1'b0, s1_y} >= {1'b0, box_y}) && ({1'b0, s1_y} < {1'b0, box_y} + BOX_W);
    if (s1_active) begin
      case (s1_mode)
        2'd0: begin
          if (bar < 10'd8 && !bar[1]) r_next = FULL;
          if (bar < 10'd4)            g_next = FULL;
          if (bar < 10'd8 && !bar[0]) b_next = FULL;
        end
        2'd1: begin
          if (s1_x[5] ^ s1_y[5]) begin
            r_next = FULL;
            g_next = FULL;
            b_next = FULL;
          end
        end
        2'd2: begin
          if (in_box) r_next = FULL;
          else        b_next = ONE;
        end
        default: begin
          r_next = (grad > FULL_10) ? FULL : grad[COLOR_BITS-1:0];
          g_next = r_next;
          b_next = r_next;
        end
      endcase
    end
  end

  always_ff @(posedge clk_25 or negedge rst) begin
    if (!rst) begin
      r_q     <= ZERO;
      g_q     <= ZERO;
      b_q     <= ZERO;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      r_q     <= r_next;
      g_q     <= g_next;
      b_q     <= b_next;
      hsync_q <= s1_hsync;
      vsync_q <= s1_vsync;
    end
  end

  assign bus.vga_r       = r_q;
  assign bus.vga_g       = g_q;
  assign bus.vga_b       = b_q;
  assign bus.hsync_out   = hsync_q;
  assign bus.vsync_out   = vsync_q;
  assign bus.frame_count = frame_count;

endmodule
